// File: rtl/rc4_message_checker_if.sv
// rc4_message_checker_if: start/verdict handshake plus decoded-message RAM read port; master = checker, slave = controller/RAM side
interface rc4_message_checker_if #(
  parameter int ADDR_WIDTH = 5
);
  logic start;
  logic busy;
  logic done;
  logic msg_valid;
  logic ram_rden;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [ADDR_WIDTH-1:0] bad_index;
  logic [7:0] ram_q;
  logic [7:0] bad_char;
  logic [ADDR_WIDTH:0] pass_count;
  modport master (
    input start, ram_q,
    output busy, done, msg_valid, ram_rden, ram_address, bad_index, bad_char, pass_count
  );
  modport slave (
    output start, ram_q,
    input busy, done, msg_valid, ram_rden, ram_address, bad_index, bad_char, pass_count
  );
endinterface

// File: rtl/rc4_message_checker.sv
// rc4_message_checker: reads MSG_LEN decoded bytes, verdict = all a-z/space; ports clk, reset (sync, active-high), bus (start/busy/done/verdicts, RAM read port)
module rc4_message_checker #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LATENCY = 1
) (
  input logic clk,
  input logic reset,
  rc4_message_checker_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] last_idx = ADDR_WIDTH'(MSG_LEN - 1);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] idx, idx_n, bad_index_n;
  logic [7:0] bad_char_n;
  logic [ADDR_WIDTH:0] pass_count_n;
  logic msg_valid_n, legal;
  assign legal = (bus.ram_q >= 8'h61 && bus.ram_q <= 8'h7a) || bus.ram_q == 8'h20;
  assign bus.ram_address = idx;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      bus.ram_rden <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.msg_valid <= 1'b0;
      bus.bad_index <= '0;
      bus.bad_char <= '0;
      bus.pass_count <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      bus.ram_rden <= state_n == READ;
      bus.busy <= state_n != IDLE;
      bus.done <= state_n == DONE;
      bus.msg_valid <= msg_valid_n;
      bus.bad_index <= bad_index_n;
      bus.bad_char <= bad_char_n;
      bus.pass_count <= pass_count_n;
    end
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    msg_valid_n = bus.msg_valid;
    bad_index_n = bus.bad_index;
    bad_char_n = bus.bad_char;
    pass_count_n = bus.pass_count;
    case (state)
      IDLE: if (bus.start) begin
        state_n = READ;
        idx_n = '0;
        msg_valid_n = 1'b0;
        bad_index_n = '0;
        bad_char_n = '0;
        pass_count_n = '0;
      end
      READ: state_n = RD_LATENCY == 2 ? WAIT : CHECK;
      WAIT: state_n = CHECK;
      CHECK: if (!legal) begin
        state_n = DONE;
        bad_index_n = idx;
        bad_char_n = bus.ram_q;
        msg_valid_n = 1'b0;
      end else begin
        pass_count_n = bus.pass_count + 1'b1;
        state_n = idx == last_idx ? DONE : READ;
        msg_valid_n = idx == last_idx;
        idx_n = idx == last_idx ? idx : idx + 1'b1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rc4_message_checker.sv
// tb_rc4_message_checker: directed scans of a RAM model through two checkers (read latency 1 and 2) with a scoreboard
module tb_rc4_message_checker;
  localparam int AW = 5;
  localparam int N = 32;
  typedef struct {
    int sel;
    int cyc;
    logic mv;
    logic [AW-1:0] bi;
    logic [7:0] bc;
    logic [AW:0] pc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int tick = 0;
  int t0 = 0;
  int done_cnt = 0;
  exp_t sb[$];
  int addr_q[$];
  exp_t mon_e;
  logic [7:0] mem [N];
  logic [7:0] d2;
  always #5 clk = ~clk;
  always @(posedge clk) tick++;
  rc4_message_checker_if #(.ADDR_WIDTH(AW)) b1 (), b2 ();
  rc4_message_checker #(.MSG_LEN(N), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut1 (
    .clk(clk),
    .reset(reset),
    .bus(b1.master)
  );
  rc4_message_checker #(.MSG_LEN(N), .ADDR_WIDTH(AW), .RD_LATENCY(2)) dut2 (
    .clk(clk),
    .reset(reset),
    .bus(b2.master)
  );
  always @(posedge clk) begin
    b1.ram_q <= b1.ram_rden ? mem[b1.ram_address] : 8'h00;
    d2 <= b2.ram_rden ? mem[b2.ram_address] : 8'h00;
    b2.ram_q <= d2;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (b1.ram_rden || b2.ram_rden) begin
        chk("rd_expected", 32'(addr_q.size() > 0), 1);
        if (addr_q.size() > 0)
          chk("rd_addr", 32'(b1.ram_rden ? b1.ram_address : b2.ram_address), addr_q.pop_front());
      end
      if (b1.done || b2.done) begin
        done_cnt++;
        chk("done_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("done_unit", 32'(b2.done), mon_e.sel);
          chk("done_cycle", tick - t0, mon_e.cyc);
          chk("msg_valid", 32'(mon_e.sel ? b2.msg_valid : b1.msg_valid), 32'(mon_e.mv));
          chk("bad_index", 32'(mon_e.sel ? b2.bad_index : b1.bad_index), 32'(mon_e.bi));
          chk("bad_char", 32'(mon_e.sel ? b2.bad_char : b1.bad_char), 32'(mon_e.bc));
          chk("pass_count", 32'(mon_e.sel ? b2.pass_count : b1.pass_count), 32'(mon_e.pc));
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic goto_cycle(input int n);
    while (tick - t0 < n) step(1);
  endtask
  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < N; i++) mem[i] = v;
  endtask
  task automatic launch(input int sel, input logic mv, input int k, input logic [7:0] bc);
    exp_t e;
    e.sel = sel;
    e.cyc = (k + 1) * (sel + 2) + 1;
    e.mv = mv;
    e.bi = mv ? '0 : AW'(k);
    e.bc = mv ? 8'h00 : bc;
    e.pc = mv ? (AW + 1)'(N) : (AW + 1)'(k);
    for (int i = 0; i <= k; i++) addr_q.push_back(i);
    sb.push_back(e);
    done_cnt = 0;
    if (sel == 1) b2.start = 1'b1;
    else b1.start = 1'b1;
    t0 = tick;
    chk("busy_cycle0", 32'(sel == 1 ? b2.busy : b1.busy), 0);
    step(1);
    b1.start = 1'b0;
    b2.start = 1'b0;
    chk("busy_cycle1", 32'(sel == 1 ? b2.busy : b1.busy), 1);
  endtask
  task automatic finish_scan(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      step(1);
      n++;
    end
    chk("scan_timeout", sb.size(), 0);
    step(2);
    chk("extra_reads", addr_q.size(), 0);
    chk("done_count", done_cnt, 1);
    sb.delete();
    addr_q.delete();
  endtask
  initial begin
    b1.start = 1'b0;
    b2.start = 1'b0;
    fill(8'h61);
    step(3);
    chk("rst_busy", 32'(b1.busy), 0);
    chk("rst_rden", 32'(b1.ram_rden), 0);
    chk("rst_done", 32'(b1.done), 0);
    chk("rst_addr", 32'(b1.ram_address), 0);
    chk("rst_mv", 32'(b1.msg_valid), 0);
    chk("rst_bi", 32'(b1.bad_index), 0);
    chk("rst_bc", 32'(b1.bad_char), 0);
    chk("rst_pc", 32'(b1.pass_count), 0);
    chk("rst_busy2", 32'(b2.busy), 0);
    reset = 1'b0;
    step(2);
    launch(0, 1'b1, 31, 8'h00);
    finish_scan(200);
    step(3);
    chk("mv_held", 32'(b1.msg_valid), 1);
    chk("busy_after", 32'(b1.busy), 0);
    fill(8'h7a);
    mem[5] = 8'h41;
    launch(0, 1'b0, 5, 8'h41);
    finish_scan(200);
    fill(8'h61);
    mem[0] = 8'h60;
    launch(0, 1'b0, 0, 8'h60);
    finish_scan(200);
    mem[0] = 8'h7b;
    launch(0, 1'b0, 0, 8'h7b);
    finish_scan(200);
    for (int i = 0; i < N; i++) mem[i] = i[0] ? 8'h7a : 8'h20;
    launch(0, 1'b1, 31, 8'h00);
    finish_scan(200);
    fill(8'h20);
    launch(1, 1'b1, 31, 8'h00);
    finish_scan(300);
    fill(8'h61);
    launch(0, 1'b1, 31, 8'h00);
    goto_cycle(20);
    reset = 1'b1;
    step(1);
    chk("mid_rst_busy", 32'(b1.busy), 0);
    chk("mid_rst_rden", 32'(b1.ram_rden), 0);
    chk("mid_rst_mv", 32'(b1.msg_valid), 0);
    chk("mid_rst_bi", 32'(b1.bad_index), 0);
    chk("mid_rst_bc", 32'(b1.bad_char), 0);
    chk("mid_rst_pc", 32'(b1.pass_count), 0);
    chk("mid_rst_done_cnt", done_cnt, 0);
    sb.delete();
    addr_q.delete();
    reset = 1'b0;
    step(1);
    launch(0, 1'b1, 31, 8'h00);
    finish_scan(200);
    launch(0, 1'b1, 31, 8'h00);
    goto_cycle(4);
    b1.start = 1'b1;
    step(1);
    b1.start = 1'b0;
    goto_cycle(30);
    b1.start = 1'b1;
    step(1);
    b1.start = 1'b0;
    goto_cycle(65);
    b1.start = 1'b1;
    step(1);
    chk("single_done", done_cnt, 1);
    chk("mv_held_c66", 32'(b1.msg_valid), 1);
    launch(0, 1'b1, 31, 8'h00);
    chk("mv_clr_c67", 32'(b1.msg_valid), 0);
    finish_scan(200);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
